fighter_renderer: RTL and testbench



---
 rtl/fighter_renderer_if.sv | 31 +++
 rtl/fighter_renderer.sv | 251 +++++++++++++++++++++++++
 tb/tb_fighter_renderer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fighter_renderer_if.sv
// Position handshake between the game logic (master) and fighter_renderer (slave).
// A position set is transferred when pos_valid and pos_ready are both high.
// Optional feature macro: FIGHTER_HEALTH_BAR_EN adds the two health fields.
interface fighter_renderer_if;
  logic       pos_valid;
  logic       pos_ready;
  logic [9:0] p1_x;
  logic [9:0] p1_y;
  logic [9:0] p2_x;
  logic [9:0] p2_y;
`ifdef FIGHTER_HEALTH_BAR_EN
  logic [6:0] p1_health;
  logic [6:0] p2_health;
`endif

  modport master (
    output pos_valid, p1_x, p1_y, p2_x, p2_y,
`ifdef FIGHTER_HEALTH_BAR_EN
    output p1_health, p2_health,
`endif
    input  pos_ready
  );

  modport slave (
    input  pos_valid, p1_x, p1_y, p2_x, p2_y,
`ifdef FIGHTER_HEALTH_BAR_EN
    input  p1_health, p2_health,
`endif
    output pos_ready
  );
endinterface

// File: rtl/fighter_renderer.sv
// fighter_renderer: pixel stage behind the VGA timing generator. Draws
// background, floor and two fighter rectangles with a fixed 3-cycle latency
// (S1 hit tests, S2 priority mux, S3 output register). New fighter positions
// land in a shadow bank and are promoted to the drawing bank only on the
// falling edge of vsync_in, so a frame is never drawn with mixed positions.
// Optional feature macro: FIGHTER_HEALTH_BAR_EN adds health bars on rows 8..15.
module fighter_renderer #(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          SPRITE_W      = 32,
  parameter int          SPRITE_H      = 64,
  parameter int          FLOOR_Y       = 400,
  parameter logic [23:0] BG_COLOR      = 24'h202040,
  parameter logic [23:0] FLOOR_COLOR   = 24'h604020,
  parameter logic [23:0] P1_COLOR      = 24'hE03030,
  parameter logic [23:0] P2_COLOR      = 24'h3060E0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [9:0]                xcoord,
  input  logic [9:0]                ycoord,
  input  logic                      display_en_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  fighter_renderer_if.slave         pos,
  output logic [7:0]                r,
  output logic [7:0]                g,
  output logic [7:0]                b,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_n,
  output logic                      frame_start
);

  localparam logic [9:0] P1_RESET_X      = 10'd100;
  localparam logic [9:0] P2_RESET_X      = 10'd508;
  localparam logic [9:0] FIGHTER_RESET_Y = 10'(FLOOR_Y - SPRITE_H);
`ifdef FIGHTER_HEALTH_BAR_EN
  localparam logic [23:0] BAR_COLOR      = 24'hF0D000;
  localparam logic [6:0]  HEALTH_MAX     = 7'd100;
`endif

  typedef struct packed {
    logic [9:0] p1x;
    logic [9:0] p1y;
    logic [9:0] p2x;
    logic [9:0] p2y;
`ifdef FIGHTER_HEALTH_BAR_EN
    logic [6:0] h1;
    logic [6:0] h2;
`endif
  } posSet_t;

  function automatic posSet_t resetSet();
    posSet_t s;
    s.p1x = P1_RESET_X;
    s.p1y = FIGHTER_RESET_Y;
    s.p2x = P2_RESET_X;
    s.p2y = FIGHTER_RESET_Y;
`ifdef FIGHTER_HEALTH_BAR_EN
    s.h1  = HEALTH_MAX;
    s.h2  = HEALTH_MAX;
`endif
    return s;
  endfunction

  // Sums are done 11 bits wide so a sprite near the edge is clipped, not wrapped.
  function automatic logic inSpan(input logic [9:0] c, input logic [9:0] origin,
                                  input logic [10:0] size);
    return ({1'b0, c} >= {1'b0, origin}) && ({1'b0, c} < ({1'b0, origin} + size));
  endfunction

`ifdef FIGHTER_HEALTH_BAR_EN
  function automatic logic [6:0] clampHealth(input logic [6:0] h);
    return (h > HEALTH_MAX) ? HEALTH_MAX : h;
  endfunction
`endif

  posSet_t    shadow_q, shadow_d;
  posSet_t    active_q, active_d;
  posSet_t    offered;
  logic       pending_q, pending_d;
  logic       vsyncPrev_q;
  logic       frameStart_q;
  logic       boundary;
  logic       accept;

  logic       onScreen;
  logic       hitP1_d, hitP2_d;
  logic       hitP1_q, hitP2_q;
  logic       de1_q, hs1_q, vs1_q;
  logic [9:0] y1_q;
`ifdef FIGHTER_HEALTH_BAR_EN
  logic       barRow;
  logic [10:0] x11, len1, len2;
  logic       hitBar_d, hitBar_q;
`endif

  logic [23:0] color2_d, color2_q;
  logic        de2_q, hs2_q, vs2_q;

  logic [23:0] rgb_q;
  logic        blank_q, hs3_q, vs3_q;

  assign boundary      = vsyncPrev_q & ~vsync_in;
  assign accept        = pos.pos_valid & ~pending_q;
  assign pos.pos_ready = ~pending_q;

  // Collect the position set currently offered on the handshake port.
  always_comb begin
    offered     = resetSet();
    offered.p1x = pos.p1_x;
    offered.p1y = pos.p1_y;
    offered.p2x = pos.p2_x;
    offered.p2y = pos.p2_y;
`ifdef FIGHTER_HEALTH_BAR_EN
    offered.h1  = clampHealth(pos.p1_health);
    offered.h2  = clampHealth(pos.p2_health);
`endif
  end

  // Promote shadow to active at a boundary; an accept on the same cycle only refills shadow.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = offered;
      pending_d = 1'b1;
    end
  end

  // Position banks, vsync edge history and the frame_start pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q     <= resetSet();
      active_q     <= resetSet();
      pending_q    <= 1'b0;
      vsyncPrev_q  <= 1'b1;
      frameStart_q <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      vsyncPrev_q  <= vsync_in;
      frameStart_q <= boundary;
    end
  end

  // S1 hit tests against the active bank.
  always_comb begin
    onScreen = (xcoord < 10'(SCREEN_WIDTH)) && (ycoord < 10'(SCREEN_HEIGHT));
    hitP1_d  = onScreen && inSpan(xcoord, active_q.p1x, 11'(SPRITE_W))
                        && inSpan(ycoord, active_q.p1y, 11'(SPRITE_H));
    hitP2_d  = onScreen && inSpan(xcoord, active_q.p2x, 11'(SPRITE_W))
                        && inSpan(ycoord, active_q.p2y, 11'(SPRITE_H));
`ifdef FIGHTER_HEALTH_BAR_EN
    barRow   = (ycoord >= 10'd8) && (ycoord <= 10'd15);
    x11      = {1'b0, xcoord};
    len1     = {3'b000, active_q.h1, 1'b0};
    len2     = {3'b000, active_q.h2, 1'b0};
    hitBar_d = barRow && (((x11 >= 11'd16) && (x11 < (11'd16 + len1)))
                       || ((x11 >= (11'(SCREEN_WIDTH - 16) - len2))
                           && (x11 < 11'(SCREEN_WIDTH - 16))));
`endif
  end

  // S1 register: coordinates, enables, syncs and hit flags. Syncs idle high.
  always_ff @(posedge clk) begin
    if (reset) begin
      de1_q   <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      y1_q    <= '0;
      hitP1_q <= 1'b0;
      hitP2_q <= 1'b0;
`ifdef FIGHTER_HEALTH_BAR_EN
      hitBar_q <= 1'b0;
`endif
    end else begin
      de1_q   <= display_en_in;
      hs1_q   <= hsync_in;
      vs1_q   <= vsync_in;
      y1_q    <= ycoord;
      hitP1_q <= hitP1_d;
      hitP2_q <= hitP2_d;
`ifdef FIGHTER_HEALTH_BAR_EN
      hitBar_q <= hitBar_d;
`endif
    end
  end

  // S2 colour priority: bars, P1, P2, floor, background.
  always_comb begin
    color2_d = BG_COLOR;
`ifdef FIGHTER_HEALTH_BAR_EN
    if (hitBar_q)
      color2_d = BAR_COLOR;
    else
`endif
    if (hitP1_q)
      color2_d = P1_COLOR;
    else if (hitP2_q)
      color2_d = P2_COLOR;
    else if ((y1_q >= 10'(FLOOR_Y)) && (y1_q < 10'(SCREEN_HEIGHT)))
      color2_d = FLOOR_COLOR;
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (reset) begin
      color2_q <= '0;
      de2_q    <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      color2_q <= color2_d;
      de2_q    <= de1_q;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
    end
  end

  // S3 output register with blanking outside the active region.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= '0;
      blank_q <= 1'b0;
      hs3_q   <= 1'b1;
      vs3_q   <= 1'b1;
    end else begin
      rgb_q   <= de2_q ? color2_q : 24'h000000;
      blank_q <= de2_q;
      hs3_q   <= hs2_q;
      vs3_q   <= vs2_q;
    end
  end

  assign r           = rgb_q[23:16];
  assign g           = rgb_q[15:8];
  assign b           = rgb_q[7:0];
  assign blank_n     = blank_q;
  assign hsync_out   = hs3_q;
  assign vsync_out   = vs3_q;
  assign frame_start = frameStart_q;

endmodule

// File: tb/tb_fighter_renderer.sv
// Directed testbench for fighter_renderer. Each test task drives its own
// stimulus and compares against hand-computed colours and flags.
module tb_fighter_renderer;

  localparam logic [23:0] BG    = 24'h202040;
  localparam logic [23:0] FLOOR = 24'h604020;
  localparam logic [23:0] P1    = 24'hE03030;
  localparam logic [23:0] P2    = 24'h3060E0;
`ifdef FIGHTER_HEALTH_BAR_EN
  localparam logic [23:0] BAR   = 24'hF0D000;
`endif

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] xcoord, ycoord;
  logic       display_en_in, hsync_in, vsync_in;
  logic [7:0] r, g, b;
  logic       hsync_out, vsync_out, blank_n, frame_start;
  int         checks = 0;
  int         errors = 0;
`ifdef FIGHTER_HEALTH_BAR_EN
  logic [6:0] nextH1 = 7'd100;
  logic [6:0] nextH2 = 7'd100;
`endif

  fighter_renderer_if posIf();

  fighter_renderer dut (
    .clk          (clk),
    .reset        (reset),
    .xcoord       (xcoord),
    .ycoord       (ycoord),
    .display_en_in(display_en_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .pos          (posIf),
    .r            (r),
    .g            (g),
    .b            (b),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .blank_n      (blank_n),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One active pixel for a single cycle, then idle; result read 3 cycles later.
  task automatic samplePix(input logic [9:0] x, input logic [9:0] y, input logic de,
                           output logic [23:0] rgb, output logic bn);
    xcoord = x; ycoord = y; display_en_in = de;
    tick();
    xcoord = 10'd0; ycoord = 10'd0; display_en_in = 1'b0;
    tick();
    tick();
    rgb = {r, g, b};
    bn  = blank_n;
  endtask

  // Offer a position set and hold it until accepted (bounded).
  task automatic offer(input logic [9:0] a, input logic [9:0] bb, input logic [9:0] c,
                       input logic [9:0] d, output logic ok);
    posIf.p1_x = a; posIf.p1_y = bb; posIf.p2_x = c; posIf.p2_y = d;
`ifdef FIGHTER_HEALTH_BAR_EN
    posIf.p1_health = nextH1;
    posIf.p2_health = nextH2;
`endif
    posIf.pos_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = posIf.pos_ready;
      tick();
    end
    posIf.pos_valid = 1'b0;
  endtask

  // One-cycle low pulse on vsync_in; reports frame_start and pos_ready right after it.
  task automatic boundary(output logic fs, output logic rdy);
    vsync_in = 1'b0;
    tick();
    fs  = frame_start;
    rdy = posIf.pos_ready;
    vsync_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    xcoord = 10'd100; ycoord = 10'd336; display_en_in = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({r, g, b} !== 24'h0) begin
      errors++; $display("[TB] FAIL reset_rgb: got %h, expected 000000", {r, g, b});
    end
    checks++;
    if ({blank_n, hsync_out, vsync_out, frame_start} !== 4'b0110) begin
      errors++; $display("[TB] FAIL reset_flags: got blank_n/hs/vs/fs=%b, expected 0110",
                         {blank_n, hsync_out, vsync_out, frame_start});
    end
    checks++;
    if (posIf.pos_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", posIf.pos_ready);
    end
    xcoord = 10'd0; ycoord = 10'd0; display_en_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    xcoord = 10'd0; ycoord = 10'd0; display_en_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    xcoord = 10'd5; ycoord = 10'd5; display_en_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    checks++;
    if ({blank_n, hsync_out} !== 2'b01) begin
      errors++; $display("[TB] FAIL latency_early: blank_n/hs=%b after 2 cycles, expected 01",
                         {blank_n, hsync_out});
    end
    tick();
    checks++;
    if ({r, g, b} !== BG || blank_n !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_pixel: rgb=%h blank_n=%b, expected %h blank_n=1",
                         {r, g, b}, blank_n, BG);
    end
    checks++;
    if ({hsync_out, vsync_out} !== 2'b00) begin
      errors++; $display("[TB] FAIL latency_sync: hs/vs=%b, expected 00", {hsync_out, vsync_out});
    end
    tick();
    checks++;
    if ({blank_n, hsync_out, vsync_out} !== 3'b011) begin
      errors++; $display("[TB] FAIL latency_after: blank_n/hs/vs=%b, expected 011",
                         {blank_n, hsync_out, vsync_out});
    end
  endtask

  task automatic test_reset_positions();
    pix_t tbl [10];
    logic [23:0] got; logic bn;
    tbl = '{'{10'd100, 10'd336, P1}, '{10'd131, 10'd399, P1}, '{10'd132, 10'd336, BG},
            '{10'd200, 10'd400, FLOOR}, '{10'd508, 10'd336, P2}, '{10'd539, 10'd399, P2},
            '{10'd540, 10'd399, BG}, '{10'd99, 10'd336, BG}, '{10'd100, 10'd335, BG},
            '{10'd100, 10'd400, FLOOR}};
    foreach (tbl[i]) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL resetpos (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask

  task automatic test_handshake();
    pix_t tbl [4];
    logic [23:0] got; logic bn, ok, fs, rdy;
    ycoord = 10'd240;
    offer(10'd200, 10'd336, 10'd508, 10'd336, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("[TB] FAIL hs_accept: accepted=%b, expected 1", ok);
    end
    checks++;
    if (posIf.pos_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL hs_ready_low: pos_ready=%b, expected 0", posIf.pos_ready);
    end
    samplePix(10'd100, 10'd336, 1'b1, got, bn);
    checks++;
    if (got !== P1) begin
      errors++; $display("[TB] FAIL hs_old_p1: rgb=%h, expected %h", got, P1);
    end
    samplePix(10'd200, 10'd336, 1'b1, got, bn);
    checks++;
    if (got !== BG) begin
      errors++; $display("[TB] FAIL hs_old_bg: rgb=%h, expected %h", got, BG);
    end
    posIf.p1_x = 10'd400; posIf.pos_valid = 1'b1;
    tick(); tick(); tick();
    posIf.pos_valid = 1'b0;
    checks++;
    if (posIf.pos_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL hs_second_offer: pos_ready=%b, expected 0", posIf.pos_ready);
    end
    boundary(fs, rdy);
    checks++;
    if ({fs, rdy} !== 2'b11) begin
      errors++; $display("[TB] FAIL hs_boundary: frame_start/pos_ready=%b, expected 11", {fs, rdy});
    end
    checks++;
    if (frame_start !== 1'b0) begin
      errors++; $display("[TB] FAIL hs_fs_pulse: frame_start=%b, expected 0", frame_start);
    end
    tbl = '{'{10'd200, 10'd336, P1}, '{10'd231, 10'd399, P1},
            '{10'd100, 10'd336, BG}, '{10'd400, 10'd336, BG}};
    foreach (tbl[i]) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL hs_new (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask

  task automatic test_frame_no_pending();
    logic [23:0] got; logic bn, fs, rdy;
    boundary(fs, rdy);
    checks++;
    if ({fs, rdy} !== 2'b11) begin
      errors++; $display("[TB] FAIL idle_boundary: frame_start/pos_ready=%b, expected 11", {fs, rdy});
    end
    samplePix(10'd200, 10'd336, 1'b1, got, bn);
    checks++;
    if (got !== P1) begin
      errors++; $display("[TB] FAIL idle_keep: rgb=%h, expected %h", got, P1);
    end
  endtask

  task automatic test_overlap();
    pix_t tbl [5];
    logic [23:0] got; logic bn, ok, fs, rdy;
    offer(10'd300, 10'd200, 10'd300, 10'd200, ok);
    boundary(fs, rdy);
    samplePix(10'd310, 10'd210, 1'b1, got, bn);
    checks++;
    if (got !== P1) begin
      errors++; $display("[TB] FAIL overlap_same: rgb=%h, expected %h", got, P1);
    end
    offer(10'd300, 10'd200, 10'd320, 10'd200, ok);
    boundary(fs, rdy);
    tbl = '{'{10'd325, 10'd210, P1}, '{10'd340, 10'd210, P2}, '{10'd351, 10'd263, P2},
            '{10'd352, 10'd210, BG}, '{10'd310, 10'd199, BG}};
    foreach (tbl[i]) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL overlap (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask

  task automatic test_clip();
    pix_t tbl [10];
    logic [23:0] got; logic bn, ok, fs, rdy;
    offer(10'd10, 10'd470, 10'd620, 10'd336, ok);
    boundary(fs, rdy);
    tbl = '{'{10'd620, 10'd336, P2}, '{10'd639, 10'd399, P2}, '{10'd619, 10'd336, BG},
            '{10'd0, 10'd336, BG}, '{10'd11, 10'd399, BG}, '{10'd10, 10'd479, P1},
            '{10'd41, 10'd470, P1}, '{10'd10, 10'd0, BG}, '{10'd10, 10'd5, BG},
            '{10'd42, 10'd470, FLOOR}};
    foreach (tbl[i]) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL clip (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask

  task automatic test_display_en();
    logic [23:0] got; logic bn;
    samplePix(10'd10, 10'd470, 1'b0, got, bn);
    checks++;
    if (got !== 24'h0 || bn !== 1'b0) begin
      errors++; $display("[TB] FAIL blanking: rgb=%h blank_n=%b, expected 000000 blank_n=0", got, bn);
    end
  endtask

  task automatic test_accept_at_boundary();
    logic [23:0] got; logic bn, fs, rdy;
    posIf.p1_x = 10'd100; posIf.p1_y = 10'd336; posIf.p2_x = 10'd508; posIf.p2_y = 10'd336;
`ifdef FIGHTER_HEALTH_BAR_EN
    posIf.p1_health = 7'd100; posIf.p2_health = 7'd100;
`endif
    posIf.pos_valid = 1'b1;
    vsync_in = 1'b0;
    tick();
    posIf.pos_valid = 1'b0;
    vsync_in = 1'b1;
    checks++;
    if ({frame_start, posIf.pos_ready} !== 2'b10) begin
      errors++; $display("[TB] FAIL coincide_flags: frame_start/pos_ready=%b, expected 10",
                         {frame_start, posIf.pos_ready});
    end
    tick();
    samplePix(10'd10, 10'd479, 1'b1, got, bn);
    checks++;
    if (got !== P1) begin
      errors++; $display("[TB] FAIL coincide_old: rgb=%h, expected %h", got, P1);
    end
    boundary(fs, rdy);
    checks++;
    if ({fs, rdy} !== 2'b11) begin
      errors++; $display("[TB] FAIL coincide_next: frame_start/pos_ready=%b, expected 11", {fs, rdy});
    end
    samplePix(10'd100, 10'd336, 1'b1, got, bn);
    checks++;
    if (got !== P1) begin
      errors++; $display("[TB] FAIL coincide_new: rgb=%h, expected %h", got, P1);
    end
    samplePix(10'd10, 10'd479, 1'b1, got, bn);
    checks++;
    if (got !== FLOOR) begin
      errors++; $display("[TB] FAIL coincide_gone: rgb=%h, expected %h", got, FLOOR);
    end
  endtask

  task automatic test_reset_mid();
    pix_t tbl [3];
    logic [23:0] got; logic bn, ok, fs, rdy;
    offer(10'd200, 10'd100, 10'd300, 10'd100, ok);
    boundary(fs, rdy);
    offer(10'd50, 10'd50, 10'd50, 10'd50, ok);
    checks++;
    if (posIf.pos_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_pending: pos_ready=%b, expected 0", posIf.pos_ready);
    end
    xcoord = 10'd200; ycoord = 10'd100; display_en_in = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    xcoord = 10'd0; ycoord = 10'd0; display_en_in = 1'b0;
    checks++;
    if ({posIf.pos_ready, blank_n} !== 2'b10) begin
      errors++; $display("[TB] FAIL midreset_state: pos_ready/blank_n=%b, expected 10",
                         {posIf.pos_ready, blank_n});
    end
    tick();
    boundary(fs, rdy);
    tbl = '{'{10'd100, 10'd336, P1}, '{10'd200, 10'd100, BG}, '{10'd50, 10'd50, BG}};
    foreach (tbl[i]) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL midreset (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask

`ifdef FIGHTER_HEALTH_BAR_EN
  task automatic test_health();
    pix_t tbl [16];
    logic [23:0] got; logic bn, ok, fs, rdy;
    nextH1 = 7'd10; nextH2 = 7'd0;
    offer(10'd100, 10'd336, 10'd508, 10'd336, ok);
    samplePix(10'd215, 10'd8, 1'b1, got, bn);
    checks++;
    if (got !== BAR) begin
      errors++; $display("[TB] FAIL bar_reset_full: rgb=%h, expected %h", got, BAR);
    end
    boundary(fs, rdy);
    nextH1 = 7'd127; nextH2 = 7'd100;
    tbl[0] = '{10'd16, 10'd8, BAR};   tbl[1] = '{10'd35, 10'd15, BAR};
    tbl[2] = '{10'd36, 10'd8, BG};    tbl[3] = '{10'd15, 10'd8, BG};
    tbl[4] = '{10'd623, 10'd8, BG};   tbl[5] = '{10'd16, 10'd16, BG};
    tbl[6] = '{10'd16, 10'd7, BG};    tbl[7] = '{10'd35, 10'd12, BAR};
    for (int i = 0; i < 8; i++) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL bar10 (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
    offer(10'd16, 10'd0, 10'd508, 10'd336, ok);
    boundary(fs, rdy);
    tbl[8]  = '{10'd215, 10'd8, BAR};  tbl[9]  = '{10'd216, 10'd8, BG};
    tbl[10] = '{10'd20, 10'd20, P1};   tbl[11] = '{10'd20, 10'd10, BAR};
    tbl[12] = '{10'd623, 10'd8, BAR};  tbl[13] = '{10'd624, 10'd8, BG};
    tbl[14] = '{10'd424, 10'd15, BAR}; tbl[15] = '{10'd423, 10'd8, BG};
    for (int i = 8; i < 16; i++) begin
      samplePix(tbl[i].x, tbl[i].y, 1'b1, got, bn);
      checks++;
      if (got !== tbl[i].c || bn !== 1'b1) begin
        errors++; $display("[TB] FAIL bar100 (%0d,%0d): rgb=%h blank_n=%b, expected %h blank_n=1",
                           tbl[i].x, tbl[i].y, got, bn, tbl[i].c);
      end
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    xcoord = 10'd0; ycoord = 10'd0; display_en_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    posIf.pos_valid = 1'b0;
    posIf.p1_x = 10'd0; posIf.p1_y = 10'd0; posIf.p2_x = 10'd0; posIf.p2_y = 10'd0;
`ifdef FIGHTER_HEALTH_BAR_EN
    posIf.p1_health = 7'd100; posIf.p2_health = 7'd100;
`endif
    test_reset();
    test_latency();
    test_reset_positions();
    test_handshake();
    test_frame_no_pending();
    test_overlap();
    test_clip();
    test_display_en();
    test_accept_at_boundary();
    test_reset_mid();
`ifdef FIGHTER_HEALTH_BAR_EN
    test_health();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
